// File: rtl/alu_result_capture.sv
// alu_result_capture: downstream stage of the alu_op pipeline.
// Delays the issue strobe through the pipeline latency so that only real
// alu_op results are captured. Captured results go into a small show-ahead
// FIFO that is drained over a valid/ready handshake. A sticky overflow flag
// and running count/sum statistics are kept for debug visibility.
module alu_result_capture #(
  parameter int W       = 10,
  parameter int LATENCY = 3,
  parameter int DEPTH   = 4,
  parameter int ACC_W   = 16,
  parameter int CNT_W   = 8
) (
  input  logic                     clk1,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [W-1:0]             F,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [W-1:0]             res_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clr_ovf,
  output logic [CNT_W-1:0]         res_count,
  output logic [ACC_W-1:0]         res_sum
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Valid alignment pipe: bit k holds issue_valid delayed by k+1 cycles.
  logic [LATENCY-1:0] vpipe;
  logic               cap;

  // FIFO storage and bookkeeping.
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_q;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic drop;

  // Zero-extended result used for the running sum (also correct if ACC_W < W).
  logic [ACC_W+W-1:0] f_ext;

  generate
    if (LATENCY == 1) begin : g_vpipe_single
      // A single-stage delay: cap follows issue_valid by one cycle.
      always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
          vpipe <= '0;
        end else begin
          vpipe <= issue_valid;
        end
      end
    end else begin : g_vpipe_multi
      // Shift issue_valid in so the top bit lines up with the matching F.
      always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
          vpipe <= '0;
        end else begin
          vpipe <= {vpipe[LATENCY-2:0], issue_valid};
        end
      end
    end
  endgenerate

  assign cap   = vpipe[LATENCY-1];
  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);

  // Handshake and capture decisions; a full FIFO still accepts a result
  // when the consumer frees a slot on the same edge.
  always_comb begin
    pop  = 1'b0;
    push = 1'b0;
    drop = 1'b0;
    pop  = !empty && res_ready;
    push = cap && (!full || pop);
    drop = cap && full && !pop;
  end

  // Result storage; contents need no reset because level gates visibility.
  always_ff @(posedge clk1) begin
    if (push) begin
      mem[wr_ptr] <= F;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Occupancy tracks push minus pop; simultaneous push and pop cancel.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      level_q <= '0;
    end else begin
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  assign f_ext = {{ACC_W{1'b0}}, F};

  // Statistics count only results that actually entered the FIFO.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      res_count <= '0;
      res_sum   <= '0;
    end else if (push) begin
      res_count <= res_count + CNT_W'(1);
      res_sum   <= res_sum + f_ext[ACC_W-1:0];
    end
  end

  // Show-ahead output: the oldest entry, forced to zero when nothing is held.
  always_comb begin
    res_data  = '0;
    res_valid = !empty;
    if (!empty) begin
      res_data = mem[rd_ptr];
    end
  end

  assign level = level_q;

endmodule

// File: tb/tb_alu_result_capture.sv
// tb_alu_result_capture: randomized and directed bench for alu_result_capture.
// The stimulus side models the alu_op pipeline (F shows the issued value
// LATENCY cycles after issue, garbage otherwise) and a queue-based reference
// FIFO; a separate monitor pops expected results whenever the DUT hands one out.
module tb_alu_result_capture;

  localparam int W       = 10;
  localparam int LATENCY = 3;
  localparam int DEPTH   = 4;
  localparam int ACC_W   = 16;
  localparam int CNT_W   = 8;
  localparam int LW      = $clog2(DEPTH) + 1;

  logic             clk1;
  logic             rst;
  logic             issue_valid;
  logic [W-1:0]     F;
  logic             res_valid;
  logic             res_ready;
  logic [W-1:0]     res_data;
  logic [LW-1:0]    level;
  logic             overflow;
  logic             clr_ovf;
  logic [CNT_W-1:0] res_count;
  logic [ACC_W-1:0] res_sum;

  alu_result_capture #(
    .W(W), .LATENCY(LATENCY), .DEPTH(DEPTH), .ACC_W(ACC_W), .CNT_W(CNT_W)
  ) dut (
    .clk1(clk1),
    .rst(rst),
    .issue_valid(issue_valid),
    .F(F),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data),
    .level(level),
    .overflow(overflow),
    .clr_ovf(clr_ovf),
    .res_count(res_count),
    .res_sum(res_sum)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  typedef struct {
    bit           v;
    logic [W-1:0] f;
  } issue_t;

  issue_t       hist[$];
  logic [W-1:0] expQ[$];
  int           mLevel;
  bit           mOvf;
  int unsigned  mCnt;
  int unsigned  mSum;
  bit           garbageMax;

  int checks = 0;
  int errors = 0;

  task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic resetModel();
    hist.delete();
    expQ.delete();
    mLevel = 0;
    mOvf   = 1'b0;
    mCnt   = 0;
    mSum   = 0;
  endtask

  task automatic checkOutput();
    checkValue("res_valid", 32'(res_valid), 32'(mLevel > 0));
    checkValue("level", 32'(level), 32'(mLevel));
    checkValue("overflow", 32'(overflow), 32'(mOvf));
    checkValue("res_count", 32'(res_count), mCnt % (1 << CNT_W));
    checkValue("res_sum", 32'(res_sum), mSum % (1 << ACC_W));
  endtask

  // One clock cycle: check the state left by the previous edge, drive the
  // next inputs, then advance the reference model to what the edge must do.
  task automatic applyStimulus(input bit issue, input logic [W-1:0] val, input bit ready, input bit clr);
    bit           cap;
    logic [W-1:0] capF;
    bit           pop, full, push, drop;
    @(negedge clk1);
    checkOutput();
    if (rst) begin
      issue_valid = 1'b0;
      res_ready   = ready;
      clr_ovf     = 1'b0;
      F           = '0;
      resetModel();
      return;
    end
    hist.push_back('{issue, val});
    cap  = 1'b0;
    capF = '0;
    if (hist.size() > LATENCY) begin
      cap  = hist[hist.size() - 1 - LATENCY].v;
      capF = hist[hist.size() - 1 - LATENCY].f;
    end
    while (hist.size() > LATENCY + 1) void'(hist.pop_front());
    F           = cap ? capF : (garbageMax ? {W{1'b1}} : W'($urandom));
    issue_valid = issue;
    res_ready   = ready;
    clr_ovf     = clr;
    pop  = (mLevel > 0) && ready;
    full = (mLevel == DEPTH);
    push = cap && (!full || pop);
    drop = cap && full && !pop;
    if (push) begin
      expQ.push_back(capF);
      mCnt++;
      mSum += capF;
    end
    mLevel = mLevel + int'(push) - int'(pop);
    if (drop) mOvf = 1'b1;
    else if (clr) mOvf = 1'b0;
  endtask

  task automatic idle(input int n, input bit ready);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, ready, 1'b0);
  endtask

  task automatic releaseReset();
    @(posedge clk1);
    #2 rst = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk1);
    #1 rst = 1'b1;
    resetModel();
    idle(2, 1'b0);
    releaseReset();
  endtask

  // Monitor: whenever the DUT hands out a result, it must be the oldest expected one.
  initial begin
    forever begin
      @(negedge clk1);
      #2;
      if (!rst) begin
        if (res_valid && res_ready) begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL pop_unexpected: got data %0d expected no result at %0t", res_data, $time);
          end else begin
            checkValue("res_data", 32'(res_data), 32'(expQ.pop_front()));
          end
        end else if (!res_valid) begin
          checkValue("res_data_empty", 32'(res_data), 32'd0);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] stream [5];
    stream = '{10'd66, 10'd112, 10'd66, 10'd49, 10'd62};
    rst = 1'b1;
    issue_valid = 1'b0;
    res_ready = 1'b0;
    clr_ovf = 1'b0;
    F = '0;
    garbageMax = 1'b0;
    resetModel();
    idle(2, 1'b0);
    checkValue("reset_level", 32'(level), 32'd0);
    checkValue("reset_data", 32'(res_data), 32'd0);
    releaseReset();

    // Single result.
    $display("[TB] single result");
    applyStimulus(1'b1, 10'd75, 1'b1, 1'b0);
    idle(6, 1'b1);
    checkValue("t1_count", 32'(res_count), 32'd1);
    checkValue("t1_sum", 32'(res_sum), 32'd75);

    // Back-to-back stream.
    $display("[TB] back-to-back stream");
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, stream[i], 1'b1, 1'b0);
    idle(6, 1'b1);
    checkValue("t2_count", 32'(res_count), 32'd5);
    checkValue("t2_sum", 32'(res_sum), 32'd355);

    // Stall, fill and overflow.
    $display("[TB] stall and fill");
    doReset();
    applyStimulus(1'b1, 10'd11, 1'b0, 1'b0);
    applyStimulus(1'b1, 10'd22, 1'b0, 1'b0);
    applyStimulus(1'b1, 10'd33, 1'b0, 1'b0);
    applyStimulus(1'b1, 10'd44, 1'b0, 1'b0);
    applyStimulus(1'b1, 10'd116, 1'b0, 1'b0);
    idle(4, 1'b0);
    checkValue("t3_level", 32'(level), 32'd4);
    checkValue("t3_overflow", 32'(overflow), 32'd1);
    checkValue("t3_count", 32'(res_count), 32'd4);
    checkValue("t3_sum", 32'(res_sum), 32'd110);
    idle(6, 1'b1);
    checkValue("t3_ovf_sticky", 32'(overflow), 32'd1);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    idle(1, 1'b1);
    checkValue("t3_ovf_cleared", 32'(overflow), 32'd0);

    // Full FIFO with a pop on the same edge as the capture.
    $display("[TB] full plus simultaneous pop");
    doReset();
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, W'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 10'd0, 1'b0, 1'b0);
    idle(2, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkValue("t4_level", 32'(level), 32'd4);
    checkValue("t4_overflow", 32'(overflow), 32'd0);
    checkValue("t4_count", 32'(res_count), 32'd5);
    idle(6, 1'b1);

    // Garbage rejection.
    $display("[TB] garbage rejection");
    garbageMax = 1'b1;
    idle(6, 1'b1);
    checkValue("t5_level", 32'(level), 32'd0);
    checkValue("t5_count", 32'(res_count), 32'd5);
    garbageMax = 1'b0;

    // Asynchronous reset with buffered and in-flight results.
    $display("[TB] reset mid-stream");
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, W'(100 + i), 1'b0, 1'b0);
    idle(2, 1'b0);
    applyStimulus(1'b1, 10'd200, 1'b0, 1'b0);
    applyStimulus(1'b1, 10'd201, 1'b0, 1'b0);
    checkValue("t6_level_before", 32'(level), 32'd3);
    @(posedge clk1);
    #3 rst = 1'b1;
    resetModel();
    #1;
    checkValue("t6_level_async", 32'(level), 32'd0);
    checkValue("t6_valid_async", 32'(res_valid), 32'd0);
    checkValue("t6_data_async", 32'(res_data), 32'd0);
    checkValue("t6_count_async", 32'(res_count), 32'd0);
    idle(2, 1'b1);
    releaseReset();
    applyStimulus(1'b1, 10'd75, 1'b1, 1'b0);
    idle(6, 1'b1);
    checkValue("t6_count_after", 32'(res_count), 32'd1);
    checkValue("t6_sum_after", 32'(res_sum), 32'd75);

    // Randomized traffic against the reference model.
    $display("[TB] random traffic");
    doReset();
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 1) == 1), W'($urandom),
                    ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
    end
    idle(12, 1'b1);
    checkValue("drain_empty", 32'(expQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_capture.md
Name: alu_result_capture

Overview:
- Downstream stage of the alu_op arithmetic pipeline.
- Tracks which alu_op outputs are real results by delaying an issue-valid strobe through the pipeline's latency.
- Captures each valid F into a small result FIFO and hands results to the consumer over a valid/ready handshake.
- Keeps running statistics and a sticky overflow flag for bench and debug visibility.

Parameters:
- W, 10: data width; matches alu_op operand and result width.
- LATENCY, 3: clock cycles from operands presented at alu_op inputs to the matching F at its output.
- DEPTH, 4: result FIFO entries; must be a power of two, at least 2.
- ACC_W, 16: width of the running result sum.
- CNT_W, 8: width of the captured-result counter.

Ports:
- clk1  input  1  single clock; the same clock that drives alu_op.
- rst  input  1  asynchronous, active-high reset.
- issue_valid  input  1  high in the cycle that a,b,c,d are applied to alu_op.
- F  input  W  alu_op result.
- res_valid  output  1  FIFO non-empty; res_data is valid.
- res_ready  input  1  consumer accepts res_data this cycle.
- res_data  output  W  oldest captured result.
- level  output  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  output  1  sticky: at least one result was dropped.
- clr_ovf  input  1  synchronous clear of overflow.
- res_count  output  CNT_W  results pushed since reset; wraps.
- res_sum  output  ACC_W  sum of pushed results, zero-extended; wraps mod 2^ACC_W.

Behaviour:
- Clocking and reset
  - Only clk1 is used.
  - While rst is high, all state clears asynchronously: valid pipe, pointers, level=0, res_valid=0, res_data=0, overflow=0, res_count=0, res_sum=0.
  - Asserting rst mid-operation discards all in-flight and buffered results; nothing is replayed.
- Valid alignment
  - LATENCY-deep shift register of issue_valid.
  - cap = vpipe[LATENCY-1], i.e. issue_valid delayed exactly LATENCY cycles. F is sampled only when cap=1.
  - F in any cycle where cap=0 is ignored, including pipeline fill garbage.
- FIFO
  - push = cap && (!full || pop).
  - pop = res_valid && res_ready.
  - full: level==DEPTH. empty: level==0.
  - Push and pop on the same edge: level unchanged. This holds when full, where the freed slot takes the new result.
  - Pop while empty has no effect (res_valid=0).
  - Write and read pointers are log2(DEPTH) bits and wrap naturally.
  - Show-ahead: res_data = mem[rd_ptr]; forced to 0 when empty.
  - No bypass: a result pushed at edge N is visible with res_valid=1 after edge N, so first-word latency is 1 cycle after cap.
  - res_data and res_valid hold stable while res_valid && !res_ready.
- Overflow
  - drop = cap && full && !pop. The result is discarded; FIFO contents, res_count and res_sum are unchanged; overflow sets.
  - clr_ovf clears overflow at the next edge.
  - If drop and clr_ovf occur in the same cycle, set wins: overflow stays 1.
- Statistics
  - On each push: res_count += 1 and res_sum += F. Both wrap.
  - Dropped results are not counted.
- Throughput
  - One capture per cycle sustained when the consumer holds res_ready=1.
  - Back-to-back issue_valid is fully supported.

Test Plan:
1. Single result: issue_valid pulse with a=10,b=12,c=6,d=3; res_ready=1 → cap exactly 3 cycles later; res_valid high 1 cycle after cap with res_data=75; res_count=1, res_sum=75.
2. Back-to-back stream of 66,112,66,49,62 with res_ready=1 → results delivered in order, one per cycle; level never exceeds 1; res_sum=355 and res_count=5 at end.
3. Stall and fill: res_ready=0; issue 5 results, the fifth being 116 → first 4 held, level=4, 5th dropped, overflow=1, res_count=4. Raise res_ready → 4 results drain in issue order; overflow stays 1 until a clr_ovf pulse clears it.
4. Full plus simultaneous pop: FIFO full, res_ready=1 in the same cycle as cap with F=0 → level stays 4, no drop, overflow=0; result 0 is read out 4 pops later.
5. Garbage rejection: F toggled to 1023 in cycles where cap=0 → no push; level, res_count and res_sum unchanged.
6. Reset mid-stream: rst asserted asynchronously with level=3 and 2 results in flight → outputs zero immediately without waiting for a clock edge. After release, the 2 in-flight captures do not appear; the next issued result (75) is the first output.
